// File: rtl/fetch_pkg.sv
// Shared fetch-side types and constants used by the instruction fetch queue and its neighbours.
package fetch_pkg;

  localparam int FETCH_PC_W           = 32;
  localparam int INST_Q_DEPTH_DEFAULT = 8;
  localparam logic [31:0] INSTR_EMPTY = 32'h0;

  typedef struct packed {
    logic [31:0]           instr;
    logic [FETCH_PC_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_queue.sv
// Circular instruction FIFO between fetch and decode with single-cycle flush.
// Optional empty-queue bypass enabled by defining INST_QUEUE_BYPASS_EN.
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = INST_Q_DEPTH_DEFAULT,
  parameter int PC_W  = FETCH_PC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     if_valid,
  output logic                     if_ready,
  input  logic [31:0]              if_instr,
  input  logic [PC_W-1:0]          if_pc,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [31:0]              id_instr,
  output logic [PC_W-1:0]          id_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Local entry shape so PC_W may differ from the shared default width.
  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          bypass;
  logic          pass_thru;
  logic          enq;
  logic          deq;
  entry_t        head;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign if_ready = !rst && !full;
  assign count    = wr_ptr - rd_ptr;
  assign head     = mem[rd_ptr[AW-1:0]];

`ifdef INST_QUEUE_BYPASS_EN
  assign bypass    = empty && if_valid && !flush && !rst;
  assign pass_thru = bypass && id_ready;
`else
  assign bypass    = 1'b0;
  assign pass_thru = 1'b0;
`endif

  assign enq = if_valid && if_ready && !pass_thru;
  assign deq = !empty && id_ready;

  always_comb begin
    id_valid = 1'b0;
    id_instr = INSTR_EMPTY;
    id_pc    = '0;
    if (!empty) begin
      id_valid = 1'b1;
      id_instr = head.instr;
      id_pc    = head.pc;
    end else if (bypass) begin
      id_valid = 1'b1;
      id_instr = if_instr;
      id_pc    = if_pc;
    end
  end

  // Pointer state: reset and flush both collapse the queue to empty.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage is not reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (enq && !flush && !rst) begin
      mem[wr_ptr[AW-1:0]] <= '{instr: if_instr, pc: if_pc};
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: vector table plus scoreboard and corner sequences.
module tb_inst_fetch_queue;

  localparam int DEPTH = 8;
  localparam int PC_W  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_instr;
  logic [PC_W-1:0] if_pc;
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_instr;
  logic [PC_W-1:0] id_pc;
  logic [CW-1:0]   count;

  int tests = 0;
  int fails = 0;

  inst_fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        vld;
    logic        rdy;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        e_ifr;
    logic        e_idv;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];
  logic [63:0] model[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0; if_instr = '0; if_pc = '0;
  endtask

  function automatic void add(input logic f, input logic v, input logic r,
                              input logic [31:0] ins, input logic [31:0] pc,
                              input logic eifr, input logic eidv,
                              input logic [31:0] eins, input logic [31:0] epc,
                              input int ecnt);
    vec_t t;
    t.flush = f; t.vld = v; t.rdy = r; t.instr = ins; t.pc = pc;
    t.e_ifr = eifr; t.e_idv = eidv; t.e_instr = eins; t.e_pc = epc; t.e_cnt = 4'(ecnt);
    vecs.push_back(t);
  endfunction

  function automatic logic [31:0] ins_k(input int k);
    return (k == 0) ? 32'h00410C85 : 32'h1000_0000 + 32'(k);
  endfunction

  function automatic logic [31:0] pc_k(input int k);
    return 32'h1C00_0000 + 32'(4 * k);
  endfunction

  task automatic sb_cycle(input logic do_push, input logic do_pop, input int n);
    logic [31:0] ins;
    logic [31:0] pc;
    ins = 32'h3000_0000 + 32'(n);
    pc  = 32'h1E00_0000 + 32'(4 * n);
    if_valid = do_push; if_instr = ins; if_pc = pc; id_ready = do_pop;
    @(posedge clk);
    if (do_push && model.size() < DEPTH) model.push_back({ins, pc});
    if (do_pop && model.size() > 0) void'(model.pop_front());
    #1 idle();
    #1;
    chk("sb_count", 64'(count), 64'(model.size()));
    chk("sb_count_le_depth", 64'(count <= CW'(DEPTH)), 64'(1));
    chk("sb_id_valid", 64'(id_valid), 64'(model.size() > 0));
    if (model.size() > 0) chk("sb_head", {id_instr, id_pc}, model[0]);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_ready", 64'(if_ready), 64'(0));
    chk("rst_id_valid", 64'(id_valid), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_id_instr", 64'(id_instr), 64'(0));
    chk("rst_id_pc", 64'(id_pc), 64'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_if_ready", 64'(if_ready), 64'(1));

    // Fill to full with decode stalled, refuse the 9th, then drain in order.
    for (int k = 0; k < DEPTH; k++)
      add(0, 1, 0, ins_k(k), pc_k(k), k < DEPTH - 1, 1, ins_k(0), pc_k(0), k + 1);
    add(0, 1, 0, 32'hDEADBEEF, 32'h1C00_0100, 0, 1, ins_k(0), pc_k(0), 8);
    add(0, 1, 1, 32'hDEADBEEF, 32'h1C00_0100, 1, 1, ins_k(1), pc_k(1), 7);
    for (int k = 2; k <= DEPTH; k++)
      add(0, 0, 1, 32'h0, 32'h0, 1, k < DEPTH,
          (k < DEPTH) ? ins_k(k) : 32'h0, (k < DEPTH) ? pc_k(k) : 32'h0, DEPTH - k);
    // Four queued entries, then a flush with a competing enqueue and dequeue.
    for (int j = 0; j < 4; j++)
      add(0, 1, 0, 32'h2000_0000 + 32'(j), 32'h1D00_0000 + 32'(4 * j),
          1, 1, 32'h2000_0000, 32'h1D00_0000, j + 1);
    add(1, 1, 1, 32'hBADC0DE0, 32'h1D00_0100, 1, 0, 32'h0, 32'h0, 0);
    add(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h0, 32'h0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      flush = vecs[i].flush; if_valid = vecs[i].vld; id_ready = vecs[i].rdy;
      if_instr = vecs[i].instr; if_pc = vecs[i].pc;
      @(posedge clk);
      #1 idle();
      #1;
      chk($sformatf("v%0d_if_ready", i), 64'(if_ready), 64'(vecs[i].e_ifr));
      chk($sformatf("v%0d_id_valid", i), 64'(id_valid), 64'(vecs[i].e_idv));
      chk($sformatf("v%0d_id_instr", i), 64'(id_instr), 64'(vecs[i].e_instr));
      chk($sformatf("v%0d_id_pc", i), 64'(id_pc), 64'(vecs[i].e_pc));
      chk($sformatf("v%0d_count", i), 64'(count), 64'(vecs[i].e_cnt));
    end

    // Scoreboard run across several pointer wraps.
    n = 0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 5; k++) begin sb_cycle(model.size() < DEPTH, 1'b0, n); n++; end
      for (int k = 0; k < 3; k++) sb_cycle(1'b0, 1'b1, n);
      for (int k = 0; k < 6; k++) begin sb_cycle(model.size() < DEPTH, 1'b0, n); n++; end
      for (int k = 0; k < DEPTH && model.size() > 0; k++) sb_cycle(1'b0, 1'b1, n);
    end
    // Overlapped push and pop at mid occupancy keeps count steady.
    for (int k = 0; k < 3; k++) begin sb_cycle(1'b1, 1'b0, n); n++; end
    for (int k = 0; k < 6; k++) begin sb_cycle(1'b1, 1'b1, n); n++; end

    // Reset mid-operation discards contents.
    rst = 1'b1; if_valid = 1'b1; if_instr = 32'h4444_4444; if_pc = 32'h1F00_0000;
    @(posedge clk);
    #1 idle();
    #1;
    chk("midrst_count", 64'(count), 64'(0));
    chk("midrst_id_valid", 64'(id_valid), 64'(0));
    chk("midrst_if_ready", 64'(if_ready), 64'(0));
    rst = 1'b0;
    model.delete();
    #1;

`ifdef INST_QUEUE_BYPASS_EN
    if_valid = 1'b1; id_ready = 1'b1; if_instr = 32'h5555_AAAA; if_pc = 32'h1C00_0200;
    #1;
    chk("byp_id_valid", 64'(id_valid), 64'(1));
    chk("byp_id_instr", 64'(id_instr), 64'h5555_AAAA);
    chk("byp_id_pc", 64'(id_pc), 64'h1C00_0200);
    @(posedge clk);
    #1 idle();
    #1;
    chk("byp_count", 64'(count), 64'(0));
    chk("byp_id_valid_after", 64'(id_valid), 64'(0));
`else
    if_valid = 1'b1; id_ready = 1'b1; if_instr = 32'h5555_AAAA; if_pc = 32'h1C00_0200;
    #1;
    chk("lat_id_valid_same_cycle", 64'(id_valid), 64'(0));
    @(posedge clk);
    #1 idle();
    #1;
    chk("lat_id_valid_next", 64'(id_valid), 64'(1));
    chk("lat_id_instr_next", 64'(id_instr), 64'h5555_AAAA);
    chk("lat_count_next", 64'(count), 64'(1));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
